// File: rtl/prog_launcher_pkg.sv
// Shared definitions for the program launcher.
// Holds the table geometry, default widths and the launcher state encoding.
package prog_launcher_pkg;

    localparam int unsigned NUM_PROGS  = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned CYC_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/launch_addr_table.sv
// Start-address register file: NUM_PROGS entries of ADDR_W bits.
// Ports: clk, rst_n_i (async, active-low, loads DEFAULT_ADDRS);
//        we_i/widx_i/wdata_i write port; ridx_i/rdata_c combinational read.
// A read in the write cycle returns the value held before that write.
module launch_addr_table
    import prog_launcher_pkg::*;
#(
    parameter int unsigned                   ADDR_W        = ADDR_W_DEF,
    parameter logic [NUM_PROGS*ADDR_W-1:0]   DEFAULT_ADDRS = '0
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [ADDR_W-1:0] rdata_c
);

    logic [ADDR_W-1:0] mem_q [NUM_PROGS];
    logic [ADDR_W-1:0] mem_d [NUM_PROGS];

    // Next table contents: single write port
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[widx_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NUM_PROGS; i++) begin
                mem_q[i] <= DEFAULT_ADDRS[i*ADDR_W +: ADDR_W];
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_c = mem_q[ridx_i];

endmodule

// File: rtl/prog_launcher.sv
// Program launcher sitting in front of the fetch unit.
// Accepts a launch request, looks up the start address, pulses start_o for one
// cycle, counts RUN cycles until halt_i and reports done/cycles/timeout.
// Ports: clk, rst_n_i (async active-low); req_valid_i/req_prog_i/req_ready_o
//        request handshake; cfg_we_i/cfg_idx_i/cfg_addr_i table write;
//        halt_i from decode; start_o/start_addr_o to fetch; run_o, done_o,
//        cycles_o, timeout_o status.
// Optional feature: define PROG_LAUNCHER_WATCHDOG_EN to end runs after
// WDOG_LIMIT RUN cycles with timeout_o=1.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int unsigned                 ADDR_W        = ADDR_W_DEF,
    parameter int unsigned                 CYC_W         = CYC_W_DEF,
    parameter logic [NUM_PROGS*ADDR_W-1:0] DEFAULT_ADDRS = (NUM_PROGS*ADDR_W)'(32'hC0_80_40_00),
    parameter int unsigned                 WDOG_LIMIT    = 4096
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    input  logic [IDX_W-1:0]  req_prog_i,
    output logic              req_ready_o,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic              halt_i,
    output logic              start_o,
    output logic [ADDR_W-1:0] start_addr_o,
    output logic              run_o,
    output logic              done_o,
    output logic [CYC_W-1:0]  cycles_o,
    output logic              timeout_o
);

`ifdef PROG_LAUNCHER_WATCHDOG_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tbl_rdata;
    logic [CYC_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic              ready_q, ready_d;
    logic              start_q, start_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic              wdog_hit;

    launch_addr_table #(
        .ADDR_W        (ADDR_W),
        .DEFAULT_ADDRS (DEFAULT_ADDRS)
    ) u_table (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .we_i    (cfg_we_i),
        .widx_i  (cfg_idx_i),
        .wdata_i (cfg_addr_i),
        .ridx_i  (req_prog_i),
        .rdata_c (tbl_rdata)
    );

    // Saturating increment of the run counter
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);

    // Unsaturated counter+1 compared in a wide domain so the limit cannot alias
    assign wdog_hit = WDOG_EN && ((64'(cnt_q) + 64'd1) == 64'(WDOG_LIMIT));

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        to_d     = to_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = tbl_rdata;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (halt_i) begin
                    cycles_d = cnt_inc;
                    to_d     = 1'b0;
                    state_d  = ST_DONE;
                end else if (wdog_hit) begin
                    cycles_d = cnt_inc;
                    to_d     = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags registered from the next state so they align with it
        ready_d = (state_d == ST_IDLE);
        start_d = (state_d == ST_LAUNCH);
        run_d   = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            to_q     <= 1'b0;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            to_q     <= to_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign start_o      = start_q;
    assign start_addr_o = addr_q;
    assign run_o        = run_q;
    assign done_o       = done_q;
    assign cycles_o     = cycles_q;
    assign timeout_o    = WDOG_EN & to_q;

endmodule
